// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IC/DC memory-port arbiter: FSM state
// encoding, requester identifiers and default bus widths.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Requester identifiers, also used as the round-robin history bit
    localparam logic REQ_IC = 1'b0;
    localparam logic REQ_DC = 1'b1;

    localparam int ADDR_W_DEF = 64;
    localparam int DATA_W_DEF = 64;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin picker. On a tie the requester that was not
// served last wins; a single request is granted directly.
module mem_arb_rr2
    import mem_port_arbiter_pkg::*;
(
    input  logic ic_req,
    input  logic dc_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    // Select the winner from the current requests and the grant history
    always_comb begin
        grant_valid = ic_req | dc_req;
        grant_id    = REQ_IC;
        if (ic_req && dc_req) begin
            grant_id = (last_grant == REQ_DC) ? REQ_IC : REQ_DC;
        end else if (dc_req) begin
            grant_id = REQ_DC;
        end else begin
            grant_id = REQ_IC;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single data-memory port between the instruction-cache and
// data-cache refill paths. One transaction is in flight at a time; the
// winner is held in BUSY until memory answers or the timer expires, and
// the result is presented for exactly one cycle in RESP.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ready,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_err,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_ready,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Last timer value before the transaction is abandoned
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t            state_r;
    logic              last_grant_r;
    logic              grant_r;
    logic [7:0]        timer_r;
    logic              ic_ready_r;
    logic              ic_err_r;
    logic [DATA_W-1:0] ic_rdata_r;
    logic              dc_ready_r;
    logic              dc_err_r;
    logic [DATA_W-1:0] dc_rdata_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;

    logic              grant_valid_s;
    logic              grant_id_s;
    logic              done_s;
    logic              done_err_s;
    logic [DATA_W-1:0] done_data_s;

    mem_arb_rr2 u_rr2 (
        .ic_req      (ic_req),
        .dc_req      (dc_req),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant_id    (grant_id_s)
    );

    // Completion condition in BUSY; memory answer takes priority over timeout
    always_comb begin
        done_s      = 1'b0;
        done_err_s  = 1'b0;
        done_data_s = '0;
        if (mem_ready) begin
            done_s      = 1'b1;
            done_err_s  = 1'b0;
            done_data_s = mem_rdata;
        end else if (timer_r == TIMER_LAST) begin
            done_s      = 1'b1;
            done_err_s  = 1'b1;
            done_data_s = '0;
        end else begin
            done_s      = 1'b0;
            done_err_s  = 1'b0;
            done_data_s = '0;
        end
    end

    // Arbitration FSM, timeout timer and registered memory/response outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            last_grant_r <= REQ_DC;
            grant_r      <= REQ_IC;
            timer_r      <= 8'd0;
            ic_ready_r   <= 1'b0;
            ic_err_r     <= 1'b0;
            ic_rdata_r   <= '0;
            dc_ready_r   <= 1'b0;
            dc_err_r     <= 1'b0;
            dc_rdata_r   <= '0;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
        end else begin
            // Response pulses last only for the single RESP cycle
            ic_ready_r <= 1'b0;
            ic_err_r   <= 1'b0;
            dc_ready_r <= 1'b0;
            dc_err_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_valid_s) begin
                        grant_r   <= grant_id_s;
                        mem_req_r <= 1'b1;
                        timer_r   <= 8'd0;
                        state_r   <= ST_BUSY;
                        if (grant_id_s == REQ_DC) begin
                            mem_we_r    <= dc_we;
                            mem_addr_r  <= dc_addr;
                            mem_wdata_r <= dc_wdata;
                        end else begin
                            mem_we_r    <= 1'b0;
                            mem_addr_r  <= ic_addr;
                            mem_wdata_r <= '0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (done_s) begin
                        mem_req_r    <= 1'b0;
                        last_grant_r <= grant_r;
                        state_r      <= ST_RESP;
                        if (grant_r == REQ_DC) begin
                            dc_ready_r <= 1'b1;
                            dc_err_r   <= done_err_s;
                            dc_rdata_r <= done_data_s;
                        end else begin
                            ic_ready_r <= 1'b1;
                            ic_err_r   <= done_err_s;
                            ic_rdata_r <= done_data_s;
                        end
                    end else begin
                        timer_r <= timer_r + 8'd1;
                    end
                end
                ST_RESP: begin
                    // Requests are deliberately ignored here so a still-high
                    // req from the finished transaction is not re-granted
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign ic_ready  = ic_ready_r;
    assign ic_err    = ic_err_r;
    assign ic_rdata  = ic_rdata_r;
    assign dc_ready  = dc_ready_r;
    assign dc_err    = dc_err_r;
    assign dc_rdata  = dc_rdata_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes the expected
// response of each transaction, a negedge monitor pops and compares
// whenever ic_ready or dc_ready is presented.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        is_dc;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ic_req;
    logic [63:0] ic_addr;
    logic        ic_ready;
    logic [63:0] ic_rdata;
    logic        ic_err;
    logic        dc_req;
    logic        dc_we;
    logic [63:0] dc_addr;
    logic [63:0] dc_wdata;
    logic        dc_ready;
    logic [63:0] dc_rdata;
    logic        dc_err;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ready;
    logic [63:0] mem_rdata;

    int   checks = 0;
    int   failures = 0;
    int   resp_count = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .ic_ready  (ic_ready),
        .ic_rdata  (ic_rdata),
        .ic_err    (ic_err),
        .dc_req    (dc_req),
        .dc_we     (dc_we),
        .dc_addr   (dc_addr),
        .dc_wdata  (dc_wdata),
        .dc_ready  (dc_ready),
        .dc_rdata  (dc_rdata),
        .dc_err    (dc_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bounded wait (in negedges) for mem_req to rise
    task automatic wait_grant(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s: mem_req did not rise within 20 cycles", name);
        end
    endtask

    task automatic push(input logic is_dc, input logic [63:0] rdata, input logic err);
        exp_t e;
        e.is_dc = is_dc;
        e.rdata = rdata;
        e.err   = err;
        sb_q.push_back(e);
    endtask

    // Monitor: every ready pulse must match the oldest expected response
    always @(negedge clk) begin
        if (reset === 1'b0 && (ic_ready === 1'b1 || dc_ready === 1'b1)) begin
            if (ic_ready === 1'b1 && dc_ready === 1'b1) begin
                chk("both_ready", 64'(ic_ready & dc_ready), 64'd0);
            end else if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_ready: ic_ready=%b dc_ready=%b, expected no pulse", ic_ready, dc_ready);
            end else begin
                mon_e = sb_q.pop_front();
                resp_count++;
                chk("resp_id", 64'(dc_ready), 64'(mon_e.is_dc));
                chk("resp_rdata", dc_ready ? dc_rdata : ic_rdata, mon_e.rdata);
                chk("resp_err", 64'(dc_ready ? dc_err : ic_err), 64'(mon_e.err));
            end
        end
    end

    initial begin
        int busy_cnt;
        reset = 1'b1; ic_req = 1'b0; ic_addr = 64'd0;
        dc_req = 1'b0; dc_we = 1'b0; dc_addr = 64'd0; dc_wdata = 64'd0;
        mem_ready = 1'b0; mem_rdata = 64'd0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req",  64'(mem_req), 64'd0);
        chk("rst_mem_we",   64'(mem_we), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_ic_ready", 64'(ic_ready), 64'd0);
        chk("rst_dc_ready", 64'(dc_ready), 64'd0);
        chk("rst_ic_err",   64'(ic_err), 64'd0);
        chk("rst_dc_err",   64'(dc_err), 64'd0);
        chk("rst_ic_rdata", ic_rdata, 64'd0);
        chk("rst_dc_rdata", dc_rdata, 64'd0);
        reset = 1'b0;

        // IC only, memory answers three cycles after mem_req
        @(negedge clk);
        ic_addr = 64'h1000; ic_req = 1'b1;
        wait_grant("ic_only_grant");
        chk("ic_only_addr",  mem_addr, 64'h1000);
        chk("ic_only_we",    64'(mem_we), 64'd0);
        chk("ic_only_wdata", mem_wdata, 64'd0);
        repeat (2) @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 64'hDEADBEEF;
        push(1'b0, 64'hDEADBEEF, 1'b0);
        @(negedge clk);
        mem_ready = 1'b0; ic_req = 1'b0;
        chk("ic_only_req_drop", 64'(mem_req), 64'd0);
        @(negedge clk);
        chk("ic_only_pulse_1cyc", 64'(ic_ready), 64'd0);
        chk("ic_only_rdata_hold", ic_rdata, 64'hDEADBEEF);

        // Ties after reset: IC, then DC, then IC again
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ic_addr = 64'h1100; dc_addr = 64'h2200; dc_we = 1'b0;
        ic_req = 1'b1; dc_req = 1'b1;
        wait_grant("tie1_grant");
        chk("tie1_ic_addr", mem_addr, 64'h1100);
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 64'hA1;
        push(1'b0, 64'hA1, 1'b0);
        @(negedge clk);
        mem_ready = 1'b0; ic_req = 1'b0;
        chk("tie2_resp_noreq", 64'(mem_req), 64'd0);
        @(negedge clk);
        chk("tie2_idle_noreq", 64'(mem_req), 64'd0);
        @(negedge clk);
        chk("tie2_dc_grant_k2", 64'(mem_req), 64'd1);
        chk("tie2_dc_addr", mem_addr, 64'h2200);
        mem_ready = 1'b1; mem_rdata = 64'hB2;
        push(1'b1, 64'hB2, 1'b0);
        @(negedge clk);
        mem_ready = 1'b0; ic_req = 1'b1;
        wait_grant("tie3_grant");
        chk("tie3_ic_addr", mem_addr, 64'h1100);
        mem_ready = 1'b1; mem_rdata = 64'hC3;
        push(1'b0, 64'hC3, 1'b0);
        @(negedge clk);
        mem_ready = 1'b0; ic_req = 1'b0; dc_req = 1'b0;
        @(negedge clk);

        // DC write, fields held stable until mem_ready
        dc_we = 1'b1; dc_addr = 64'h2008; dc_wdata = 64'h55; dc_req = 1'b1;
        wait_grant("dcw_grant");
        for (int i = 0; i < 3; i++) begin
            chk("dcw_req",   64'(mem_req), 64'd1);
            chk("dcw_we",    64'(mem_we), 64'd1);
            chk("dcw_addr",  mem_addr, 64'h2008);
            chk("dcw_wdata", mem_wdata, 64'h55);
            @(negedge clk);
        end
        mem_ready = 1'b1; mem_rdata = 64'h77;
        push(1'b1, 64'h77, 1'b0);
        @(negedge clk);
        mem_ready = 1'b0; dc_req = 1'b0; dc_we = 1'b0; dc_wdata = 64'd0;
        @(negedge clk);

        // Timeout (TIMEOUT=8): eight BUSY cycles then an error response
        dc_addr = 64'h3000; dc_req = 1'b1;
        wait_grant("to_grant");
        push(1'b1, 64'd0, 1'b1);
        busy_cnt = 1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) busy_cnt++;
        end
        chk("to_busy_cycles", 64'(busy_cnt), 64'd8);
        @(negedge clk);
        chk("to_req_drop", 64'(mem_req), 64'd0);
        dc_req = 1'b0; ic_addr = 64'h4000; ic_req = 1'b1;
        @(negedge clk);
        chk("to_resp_noreq", 64'(mem_req), 64'd0);
        @(negedge clk);
        chk("to_idle_regrant", 64'(mem_req), 64'd1);
        chk("to_regrant_addr", mem_addr, 64'h4000);

        // Reset mid-transaction acts without a clock edge
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_mem_req",  64'(mem_req), 64'd0);
        chk("arst_ic_ready", 64'(ic_ready), 64'd0);
        chk("arst_dc_err",   64'(dc_err), 64'd0);
        chk("arst_ic_rdata", ic_rdata, 64'd0);
        chk("arst_dc_rdata", dc_rdata, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_grant("arst_regrant");
        chk("arst_regrant_addr", mem_addr, 64'h4000);
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 64'h99;
        push(1'b0, 64'h99, 1'b0);
        @(negedge clk);

        // Stale request held through RESP and mem_ready pulsed in IDLE
        mem_ready = 1'b0;
        chk("stale_resp_noreq", 64'(mem_req), 64'd0);
        @(negedge clk);
        ic_req = 1'b0; mem_ready = 1'b1;
        chk("stale_no_regrant", 64'(mem_req), 64'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        chk("stale_idle_noreq", 64'(mem_req), 64'd0);
        chk("stale_no_ready", 64'(ic_ready | dc_ready), 64'd0);
        repeat (3) @(negedge clk);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        chk("resp_count", 64'(resp_count), 64'd7);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between the instruction cache (IC) and the data cache (DC) miss/refill paths.
- Accepts a line-fill or write request from either cache, arbitrates round-robin, and drives the memory request/ready handshake.
- Returns read data, or an error on timeout, to the granted requester.
- Sits between both caches' memory_request/memory_ready/memory_data interfaces and the data memory.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width (one cache line per transfer)
TIMEOUT, 255, max cycles waiting for mem_ready before aborting; must be at least 1 and fit in 8 bits

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
ic_req  input  1  IC request; held high until ic_ready is seen
ic_addr  input  ADDR_W  IC fill address; stable while ic_req is high
ic_ready  output  1  one-cycle pulse: IC transaction complete
ic_rdata  output  DATA_W  IC fill data; valid while ic_ready is high
ic_err  output  1  qualifies ic_ready: transaction timed out
dc_req  input  1  DC request; held high until dc_ready is seen
dc_we  input  1  DC write (1) or read (0); stable with dc_req
dc_addr  input  ADDR_W  DC address
dc_wdata  input  DATA_W  DC write data
dc_ready  output  1  one-cycle pulse: DC transaction complete
dc_rdata  output  DATA_W  DC read data; valid while dc_ready is high
dc_err  output  1  qualifies dc_ready: transaction timed out
mem_req  output  1  request to memory
mem_we  output  1  write enable to memory
mem_addr  output  ADDR_W  address to memory
mem_wdata  output  DATA_W  write data to memory
mem_ready  input  1  memory completion, sampled only in BUSY
mem_rdata  input  DATA_W  memory read data, valid with mem_ready

Behaviour:
- Outputs are registered.
- On reset (takes effect immediately, including mid-transaction):
  - state=IDLE, last_grant=DC, timer=0.
  - All outputs 0, including mem_req, both ready/err pulses, and both rdata busses.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If only one request is high, grant it.
  - If both are high, grant the requester not equal to last_grant.
  - On the grant edge: latch addr/we/wdata into the mem_* registers, set mem_req=1, timer=0, go to BUSY.
  - IC grants always drive mem_we=0 and mem_wdata=0.
- BUSY:
  - mem_req and all mem_* registers stay stable; timer increments each cycle.
  - On the edge where mem_ready=1:
    - mem_req=0.
    - Granted rdata=mem_rdata; granted ready=1; err=0.
    - last_grant=granted requester; go to RESP.
  - If timer reaches TIMEOUT-1 with mem_ready=0:
    - mem_req=0, rdata=0, ready=1, err=1.
    - last_grant updated; go to RESP.
  - mem_ready wins if it is high on the same cycle as the timeout.
- RESP:
  - ready/err are high for exactly this cycle; they clear on the next edge, which unconditionally returns to IDLE.
  - rdata holds its value until the next completion for that requester.
  - Requests are not sampled in RESP, so a req still high from the finished transaction cannot be re-granted.
- Latency, with req high at edge 0: mem_req high after edge 0; if mem_ready is sampled at edge k, ready is high after edge k; the earliest next grant is edge k+2.
- A DC write completes on mem_ready like a read; dc_rdata is loaded with mem_rdata regardless.
- mem_ready in IDLE or RESP is ignored.
- A requester dropping req while in BUSY does not abort the transaction; it completes, and the ready pulse is still issued.
- Ungranted requesters never see ready.

Decomposition:
- Shared package:
  - state encoding (IDLE/BUSY/RESP).
  - requester-id constants (REQ_IC=0, REQ_DC=1).
  - ADDR_W and DATA_W defaults.
- One sub-module, mem_arb_rr2: combinational 2-way round-robin picker.
  - Inputs: two reqs and last_grant.
  - Outputs: grant_valid and grant_id.
- The FSM, timer and data-path registers stay in the top-level module.

Test Plan:
- IC only: ic_req=1, ic_addr=0x1000; mem_ready=1 three cycles after mem_req with mem_rdata=0xDEADBEEF -> mem_addr=0x1000 and mem_we=0; ic_ready pulses exactly 1 cycle with ic_rdata=0xDEADBEEF and ic_err=0.
- Simultaneous requests after reset: ic_req=dc_req=1 -> IC granted first (last_grant resets to DC). DC is granted at the next IDLE with mem_addr=dc_addr. A third tie after that grants IC again.
- DC write: dc_we=1, dc_addr=0x2008, dc_wdata=0x55 -> mem_we=1, mem_addr=0x2008 and mem_wdata=0x55 held stable until mem_ready; then dc_ready pulses once.
- Timeout: TIMEOUT=8, mem_ready held 0 -> mem_req drops after 8 cycles in BUSY; dc_ready=1, dc_err=1, dc_rdata=0; FSM back in IDLE two edges later.
- Reset mid-transaction: assert reset while in BUSY -> mem_req, ready and err go to 0 immediately without waiting for a clock edge. After reset releases, a held ic_req is granted cleanly.
- Stale request: requester holds req through RESP and mem_ready is pulsed in IDLE -> no spurious ready pulse; a new transaction starts only from IDLE.
